// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared types and helpers for the pipelined add/subtract unit.
//   - op_e    : operation select (OP_ADD / OP_SUB)
//   - chunk_w : bits handled per pipeline stage
//   The per-beat struct depends on WIDTH, so it is declared inside
//   pipelined_adder, where WIDTH is known.
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // WIDTH must be a multiple of STAGES; each stage ripples this many bits.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Combinational ripple-carry chain of CHUNK full-adder cells.
//   Ports:
//     a, b   in  CHUNK  operand bits of this chunk (b already inverted for SUB)
//     cin    in  1      carry into bit 0
//     sum    out CHUNK  chunk result
//     cout   out 1      carry out of the chunk MSB
//     c_msb  out 1      carry into the chunk MSB, used for signed overflow
// -----------------------------------------------------------------------------
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout  = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit add/subtract unit split into STAGES ripple-carry chunks with the
//   carry registered between chunks. One beat per cycle, latency STAGES.
//   Ports:
//     clk        in   1      rising-edge clock
//     reset_n    in   1      asynchronous active-low reset
//     in_valid   in   1      operand beat offered
//     in_ready   out  1      beat accepted this cycle (= pipeline advances)
//     a, b       in   WIDTH  operands
//     cin        in   1      carry-in (ADD) / borrow-in (SUB)
//     op         in   op_e   OP_ADD / OP_SUB
//     out_valid  out  1      result beat present
//     out_ready  in   1      downstream takes the result
//     sum        out  WIDTH  result
//     cout       out  1      carry out (ADD); SUB: 1 = no borrow
//     ovf        out  1      signed overflow of the WIDTH-bit result
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    // One beat in flight. Operand chunks above the current stage are still
    // unconsumed; sum chunks at or below it are final. b and carry are stored
    // already inverted for SUB, so every stage is a plain adder.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic             valid;
    } beat_t;

    beat_t entry;
    beat_t stage_in  [STAGES];
    beat_t stage_out [STAGES];
    beat_t pipe_q    [STAGES];
    logic  adv;

    // Global stall: the whole pipeline moves only when the output slot is
    // free or is being drained this cycle. Bubbles are kept, not collapsed.
    assign adv      = !pipe_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    // SUB is a + ~b + ~cin; the inversion is done once, here at entry.
    // NOTE: every field gets a value on every pass of this always_comb, so
    // no latch can be inferred for any part of the struct.
    always_comb begin
        entry.a     = a;
        entry.b     = (op == OP_SUB) ? ~b : b;
        entry.sum   = '0;
        entry.carry = (op == OP_SUB) ? ~cin : cin;
        entry.ovf   = 1'b0;
        entry.valid = in_valid;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] slice_sum;
        logic             slice_cout;
        logic             slice_c_msb;
        beat_t            nxt;

        if (k == 0) begin : g_first
            assign stage_in[k] = entry;
        end else begin : g_chain
            assign stage_in[k] = pipe_q[k-1];
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a     (stage_in[k].a[k*CHUNK +: CHUNK]),
            .b     (stage_in[k].b[k*CHUNK +: CHUNK]),
            .cin   (stage_in[k].carry),
            .sum   (slice_sum),
            .cout  (slice_cout),
            .c_msb (slice_c_msb)
        );

        // Only the last stage's ovf is observed; there c_msb is the carry
        // into the word MSB and slice_cout the carry out of it.
        always_comb begin
            nxt                        = stage_in[k];
            nxt.sum[k*CHUNK +: CHUNK]  = slice_sum;
            nxt.carry                  = slice_cout;
            nxt.ovf                    = slice_c_msb ^ slice_cout;
        end

        assign stage_out[k] = nxt;
    end

    // Payload loads only alongside a valid beat, so after reset the output
    // fields stay at 0 until the first real result arrives, and bubbles
    // never disturb the previously emitted values.
    // NOTE: the stage registers are few and wide, not a memory array, so they
    // are all cleared by reset; that is what makes sum/cout/ovf read 0 before
    // the first result and discards any beat in flight.
    // NOTE: state updates use non-blocking assignments so every stage samples
    // the pre-edge value of its predecessor, independent of loop order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                if (stage_out[k].valid) begin
                    pipe_q[k] <= stage_out[k];
                end else begin
                    pipe_q[k].valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = pipe_q[STAGES-1].valid;
    assign sum       = pipe_q[STAGES-1].sum;
    assign cout      = pipe_q[STAGES-1].carry;
    assign ovf       = pipe_q[STAGES-1].ovf;

endmodule
